// File: rtl/turbo_rsc_encoder.sv
// Dual 8-state RSC constituent encoders for the turbo encoder: streams systematic
// and both parity bits, then holds final states on q/p while term_en is asserted.
module turbo_rsc_encoder #(
  parameter int KW          = 13,
  parameter int TERM_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] blk_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          x,
  input  logic          xi,
  output logic          out_valid,
  output logic          d0,
  output logic          d1,
  output logic          d2,
  output logic [2:0]    q,
  output logic [2:0]    p,
  output logic          term_en,
  output logic          busy,
  output logic          done
);

  localparam int TW = (TERM_CYCLES > 1) ? $clog2(TERM_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TERM_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, TERM} state_t;

  state_t        state_q;
  logic [KW-1:0] len_q;
  logic [KW-1:0] cnt_q;
  logic [TW-1:0] tcnt_q;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    s1_d, s2_d;
  logic          a1, a2, z1, z2;
  logic          ov_q, d0_q, d1_q, d2_q, done_q;
  logic          accept;

  // State bit 0 is the newest stage (s0), bit 2 the oldest (s2).
  always_comb begin
    a1   = x ^ s1_q[1] ^ s1_q[2];
    z1   = a1 ^ s1_q[0] ^ s1_q[2];
    s1_d = {s1_q[1:0], a1};
    a2   = xi ^ s2_q[1] ^ s2_q[2];
    z2   = a2 ^ s2_q[0] ^ s2_q[2];
    s2_d = {s2_q[1:0], a2};
  end

  assign accept = in_valid && (state_q == DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      ov_q    <= 1'b0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
      d2_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ov_q   <= accept;
      done_q <= 1'b0;
      if (accept) begin
        d0_q  <= x;
        d1_q  <= z1;
        d2_q  <= z2;
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        cnt_q <= cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start && (blk_len != '0)) begin
            state_q <= DATA;
            len_q   <= blk_len;
            cnt_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
          end
        end
        DATA: begin
          // Compare against K-1 so K = 2^KW-1 completes without the counter wrapping.
          if (accept && (cnt_q == len_q - 1'b1)) begin
            state_q <= TERM;
            tcnt_q  <= '0;
          end
        end
        TERM: begin
          if (tcnt_q == TLAST) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == DATA);
  assign term_en   = (state_q == TERM);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = ov_q;
  assign d0        = d0_q;
  assign d1        = d1_q;
  assign d2        = d2_q;
  assign q         = s1_q;
  assign p         = s2_q;

endmodule

// File: tb/tb_turbo_rsc_encoder.sv
// Bench for turbo_rsc_encoder: table vectors, hand-written corner sequences and
// random blocks against a reference RSC model with an output scoreboard.
module tb_turbo_rsc_encoder;
  localparam int KW = 13;
  localparam int TC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] blk_len = '0;
  logic          in_valid = 1'b0;
  logic          x = 1'b0;
  logic          xi = 1'b0;
  logic          in_ready, out_valid, d0, d1, d2, term_en, busy, done;
  logic [2:0]    q, p;

  turbo_rsc_encoder #(.KW(KW), .TERM_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .xi(xi),
    .out_valid(out_valid), .d0(d0), .d1(d1), .d2(d2),
    .q(q), .p(p), .term_en(term_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit x;
    bit xi;
    bit d0;
    bit d1;
    bit d2;
  } vec_t;

  int         chk = 0;
  int         err = 0;
  logic [2:0] sb[$];
  logic [2:0] m1, m2;
  bit         xv[64];
  bit         xiv[64];
  vec_t       tab[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {parity, next_state}.
  function automatic logic [3:0] rsc(input logic [2:0] s, input logic b);
    logic a;
    a = b ^ s[1] ^ s[2];
    return {a ^ s[0] ^ s[2], s[1], s[0], a};
  endfunction

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) check("spurious_out_valid", 32'(out_valid), 32'd0);
      else check("d0d1d2", 32'({d0, d1, d2}), 32'(sb.pop_front()));
    end
  end

  task automatic step(input bit v, input bit bx, input bit bxi, input int tabi, output bit acc);
    logic       rdy;
    logic [3:0] r1, r2;
    in_valid = v;
    x        = bx;
    xi       = bxi;
    rdy      = in_ready;
    @(posedge clk);
    acc = v && (rdy === 1'b1);
    if (acc) begin
      r1 = rsc(m1, bx);
      r2 = rsc(m2, bxi);
      if (tabi >= 0) sb.push_back({tab[tabi].d0, tab[tabi].d1, tab[tabi].d2});
      else sb.push_back({bx, r1[3], r2[3]});
      m1 = r1[2:0];
      m2 = r2[2:0];
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_block(input int k, input int mode, input int tabbase, input bit noise);
    int i, cyc, tc;
    bit acc, v;
    start   = 1'b1;
    blk_len = KW'(k);
    @(posedge clk);
    #1;
    start = 1'b0;
    m1 = '0;
    m2 = '0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(in_ready), 32'd1);
    i   = 0;
    cyc = 0;
    while (i < k && cyc < 4 * k + 20) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        blk_len = KW'($urandom_range(1, 7));
      end
      step(v, xv[i], xiv[i], (tabbase >= 0) ? tabbase + i : -1, acc);
      if (acc) i++;
      cyc++;
    end
    check("bits_accepted", 32'(i), 32'(k));
    check("term_en_first", 32'(term_en), 32'd1);
    check("ready_in_term", 32'(in_ready), 32'd0);
    check("last_out_valid", 32'(out_valid), 32'd1);
    check("q_final", 32'(q), 32'(m1));
    check("p_final", 32'(p), 32'(m2));
    tc = 1;
    while (tc < 20) begin
      if (noise) begin
        start   = 1'b1;
        blk_len = KW'(9);
      end
      @(posedge clk);
      #1;
      if (term_en !== 1'b1) begin
        start = 1'b0;
        break;
      end
      check("q_hold_term", 32'({q, p}), 32'({m1, m2}));
      tc++;
    end
    check("term_len", 32'(tc), 32'(TC));
    check("done_pulse", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("qp_at_done", 32'({q, p}), 32'({m1, m2}));
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int k;
    tab[0] = '{x: 1'b1, xi: 1'b0, d0: 1'b1, d1: 1'b1, d2: 1'b0};
    tab[1] = '{x: 1'b0, xi: 1'b0, d0: 1'b0, d1: 1'b1, d2: 1'b0};
    tab[2] = '{x: 1'b0, xi: 1'b0, d0: 1'b0, d1: 1'b1, d2: 1'b0};
    tab[3] = '{x: 1'b0, xi: 1'b0, d0: 1'b0, d1: 1'b1, d2: 1'b0};
    tab[4] = '{x: 1'b1, xi: 1'b1, d0: 1'b1, d1: 1'b1, d2: 1'b1};
    m1 = '0;
    m2 = '0;

    // Reset with random inputs
    for (int c = 0; c < 2; c++) begin
      start    = 1'($urandom_range(0, 1));
      blk_len  = KW'($urandom_range(0, 20));
      in_valid = 1'($urandom_range(0, 1));
      x        = 1'($urandom_range(0, 1));
      xi       = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check("rst_outputs", 32'({in_ready, out_valid, d0, d1, d2, term_en, busy, done}), 32'd0);
    check("rst_qp", 32'({q, p}), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Table vector K=4, continuous then alternate stalls
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 4; j++) begin
        xv[j]  = tab[j].x;
        xiv[j] = tab[j].xi;
      end
      run_block(4, s, 0, 1'b0);
      check("tab_q", 32'(q), 32'h3);
      check("tab_p", 32'(p), 32'h0);
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
    end

    // start noise during DATA and TERM
    for (int j = 0; j < 5; j++) begin
      xv[j]  = 1'($urandom_range(0, 1));
      xiv[j] = 1'($urandom_range(0, 1));
    end
    run_block(5, 2, -1, 1'b1);
    @(posedge clk);
    #1;
    check("idle_after_noise", 32'(busy), 32'd0);

    // blk_len = 0 is ignored
    start   = 1'b1;
    blk_len = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("zero_len_busy", 32'(busy), 32'd0);
    check("zero_len_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("zero_len_term", 32'({term_en, done}), 32'd0);

    // Reset after 2 of 4 bits
    start   = 1'b1;
    blk_len = KW'(4);
    @(posedge clk);
    #1;
    start = 1'b0;
    m1 = '0;
    m2 = '0;
    step(1'b1, 1'b1, 1'b1, -1, acc);
    step(1'b1, 1'b0, 1'b1, -1, acc);
    step(1'b0, 1'b0, 1'b0, -1, acc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_outputs", 32'({in_ready, out_valid, d0, d1, d2, term_en, busy, done}), 32'd0);
    check("abort_qp", 32'({q, p}), 32'd0);
    check("abort_sb", 32'(sb.size()), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check("abort_no_term", 32'({term_en, done, busy}), 32'd0);
    end

    // K=1 table vector
    xv[0]  = tab[4].x;
    xiv[0] = tab[4].xi;
    run_block(1, 0, 4, 1'b0);
    check("k1_q", 32'(q), 32'h1);
    check("k1_p", 32'(p), 32'h1);

    // Random back-to-back blocks
    for (int b = 0; b < 8; b++) begin
      k = (b == 0) ? 64 : int'($urandom_range(1, 64));
      for (int j = 0; j < k; j++) begin
        xv[j]  = 1'($urandom_range(0, 1));
        xiv[j] = 1'($urandom_range(0, 1));
      end
      run_block(k, (b % 3 == 0) ? 0 : 2, -1, 1'b0);
    end
    @(posedge clk);
    #1;
    check("final_idle", 32'({done, busy, term_en}), 32'd0);
    check("final_sb", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule

// File: doc/turbo_rsc_encoder.md
# turbo_rsc_encoder

Dual constituent-encoder stage of the turbo encoder. It accepts a block of systematic bits and their interleaved counterparts, runs the two 8-state recursive systematic convolutional (RSC) encoders, and streams the systematic bit and both parity bits. At end of block it freezes both encoder states on `q`/`p` and drives `term_en` for the trellis-termination stage directly downstream, which produces the tail bits from those states.

## Interface
Parameters:
- `KW`, 13: width of block-length field.
- `TERM_CYCLES`, 4: number of cycles `term_en` is held high.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin block; sampled only in IDLE.
- `blk_len`  in  KW  block length K in bits, sampled with `start`.
- `in_valid`  in  1  `x`/`xi` valid.
- `in_ready`  out  1  block accepts a bit this cycle.
- `x`  in  1  systematic bit.
- `xi`  in  1  interleaved bit (encoder 2 input).
- `out_valid`  out  1  `d0..d2` valid.
- `d0`  out  1  systematic output.
- `d1`  out  1  encoder-1 parity.
- `d2`  out  1  encoder-2 parity.
- `q`  out  3  encoder-1 state, {s2,s1,s0}.
- `p`  out  3  encoder-2 state, {s2,s1,s0}.
- `term_en`  out  1  termination enable to downstream stage.
- `busy`  out  1  high in DATA and TERM.
- `done`  out  1  one-cycle pulse at end of TERM.

## Operation
- Each encoder has state s0 (newest), s1, s2.
  - Feedback: a = in ^ s1 ^ s2.
  - Parity: z = a ^ s0 ^ s2.
  - Next state: s0←a, s1←s0, s2←s1.
  - Encoder 1 input is `x`; encoder 2 input is `xi`.
- States advance only on an accepted bit (`in_valid & in_ready`).
- FSM states: IDLE, DATA, TERM.
- IDLE:
  - `in_ready`=0.
  - `start` with `blk_len`≠0: clear both states to 0, latch K, clear bit counter, go to DATA.
  - `start` with `blk_len`=0: ignored; remain in IDLE.
- DATA:
  - `in_ready`=1.
  - On each accepted bit, register `d0`=x, `d1`=z1, `d2`=z2 and set `out_valid`, then increment the counter.
  - When the K-th bit is accepted, go to TERM.
  - Cycles with `in_valid`=0 are stalls: states hold and `out_valid`=0 on the next cycle.
- TERM:
  - `in_ready`=0 and `term_en`=1 for exactly TERM_CYCLES cycles.
  - `q`/`p` hold the final states throughout.
  - On the last TERM cycle, go to IDLE and pulse `done` on the following cycle.
- `start` is ignored while `busy`=1.
- `q`/`p` are the live state registers:
  - they change during DATA;
  - they are stable in TERM and IDLE until the next accepted `start`.
- Counter width is KW. K = 2^KW−1 is legal, with no wrap before completion.

## Timing
- Reset (synchronous `rst`) gives:
  - FSM in IDLE;
  - `in_ready`=0, `out_valid`=0, `d0`=`d1`=`d2`=0;
  - `q`=`p`=3'b000;
  - `term_en`=0, `busy`=0, `done`=0.
- `rst` mid-block aborts immediately. No `done` or `term_en` is issued, and any partial state is discarded.
- Latency is 1 cycle from an accepted bit to the corresponding `d0..d2`/`out_valid`.
- Cycle after `start` (blk_len≠0): DATA, `busy`=1, `in_ready`=1.
- Cycle after the K-th acceptance:
  - FSM in TERM, `term_en`=1, `in_ready`=0;
  - `out_valid`=1 for that final bit, so the final bit's output and the first `term_en` cycle coincide.
- `term_en` is high TERM_CYCLES consecutive cycles. `done` is high the cycle after `term_en` falls, with FSM in IDLE and `busy`=0.
- `in_ready` depends only on FSM state, never on `in_valid`.
- Back-to-back blocks: a `start` in the same cycle `done` is high is accepted.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs -> all outputs 0, `q`=`p`=0, `in_ready`=0.
- K=4, x=1,0,0,0, xi=0,0,0,0, `in_valid` continuous -> outputs:
  - `d0`=1,0,0,0;
  - `d1`=1,1,1,1;
  - `d2`=0,0,0,0;
  - then `q`=3'b011, `p`=3'b000;
  - `term_en` high 4 cycles, then `done` 1 cycle.
- Same K=4 vector with `in_valid` deasserted on alternate cycles -> identical `d1` sequence and final `q`=3'b011; `out_valid` pulses only after accepted bits.
- `start` asserted during DATA and TERM with different `blk_len` -> ignored; block ends after the original K. `start` with `blk_len`=0 in IDLE -> stays IDLE.
- `rst` after 2 of 4 bits -> outputs return to reset values, no `term_en`. A new K=1 block with x=1, xi=1 -> `d1`=`d2`=1, `q`=`p`=3'b001.
- Random K in 1..64, random x/xi and stalls versus a reference model -> bit-exact `d0..d2`, `q`, `p`, and exact `term_en`/`done` timing.
